summation_control: RTL and testbench

//   Control FSM for the summation datapath (accumulator + adder + term counter).

---
 rtl/summation_control.sv | 130 +++++++++++++
 tb/tb_summation_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/summation_control.sv
// Control FSM for the summation datapath: sequences set/rac at the start of a run, then
// cac/dec per accepted term, and reports done, an overflow error or a timeout error.
module summation_control #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned TW         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       value_valid,
  input  logic       nill,
  input  logic       overflow,
  output logic       value_ready,
  output logic       set,
  output logic       rac,
  output logic       dec,
  output logic       cac,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] term_count
);

  typedef enum logic [2:0] {StIdle, StInit, StWait, StDone, StError} state_e;

  localparam logic [1:0]    ErrNone     = 2'b00;
  localparam logic [1:0]    ErrOverflow = 2'b01;
  localparam logic [1:0]    ErrTimeout  = 2'b10;
  localparam logic [TW-1:0] WaitLast    = TW'(WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    term_cnt_q, term_cnt_d;
  logic [1:0]    err_q, err_d;
  logic          transfer;
  logic          timeout_hit;

  assign value_ready = (state_q == StWait) && !nill;
  assign transfer    = value_valid && value_ready;
  assign timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == WaitLast);
  assign busy        = (state_q == StInit) || (state_q == StWait);
  assign error       = (state_q == StError);
  assign err_code    = err_q;
  assign term_count  = term_cnt_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    term_cnt_d = term_cnt_q;
    err_d      = err_q;
    set        = 1'b0;
    rac        = 1'b0;
    dec        = 1'b0;
    cac        = 1'b0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        set        = 1'b1;
        rac        = 1'b1;
        term_cnt_d = '0;
        err_d      = ErrNone;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (nill) begin
          state_d = StDone;
        end else if (transfer) begin
          if (overflow) begin
            // Blocking cac leaves the last good sum in the accumulator.
            err_d   = ErrOverflow;
            state_d = StError;
          end else begin
            cac        = 1'b1;
            dec        = 1'b1;
            wait_cnt_d = '0;
            if (term_cnt_q != 8'hff) term_cnt_d = term_cnt_q + 8'd1;
          end
        end else if (timeout_hit) begin
          err_d   = ErrTimeout;
          state_d = StError;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = start ? StInit : StIdle;
      end
      StError: begin
        if (start) state_d = StInit;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything: no strobes this cycle and no bookkeeping updates.
    if (abort) begin
      state_d    = StIdle;
      wait_cnt_d = wait_cnt_q;
      term_cnt_d = term_cnt_q;
      err_d      = err_q;
      set        = 1'b0;
      rac        = 1'b0;
      dec        = 1'b0;
      cac        = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      term_cnt_q <= '0;
      err_q      <= ErrNone;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      term_cnt_q <= term_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_summation_control.sv
// Directed bench for summation_control with a behavioural model of the operating block
// (term counter + accumulator + adder carry-out).
module tb_summation_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, value_valid = 1'b0;
  logic       nill, overflow;
  logic       value_ready, set, rac, dec, cac, busy, done, error;
  logic [1:0] err_code;
  logic [7:0] term_count;
  logic [7:0] value = 8'd0;

  // Operating block model
  logic [7:0] n_load = 8'd0;
  logic [7:0] cnt_m = 8'd0;
  logic [7:0] acc_m = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  // Snapshot order: ready set rac dec cac busy done error err_code[1:0]
  localparam int IReady = 9, ISet = 8, IRac = 7, IDec = 6, ICac = 5;
  localparam int IBusy = 4, IDone = 3, IErr = 2;
  logic [9:0] s_o;
  logic [7:0] s_tc;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       valid;
    logic [7:0] value;
    logic [9:0] exp_o;
    logic [7:0] exp_tc;
  } vec_t;

  vec_t tbl [14];

  summation_control #(.WAIT_LIMIT(16), .TW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .value_valid (value_valid),
    .nill        (nill),
    .overflow    (overflow),
    .value_ready (value_ready),
    .set         (set),
    .rac         (rac),
    .dec         (dec),
    .cac         (cac),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .term_count  (term_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (set) cnt_m <= n_load;
    else if (dec) cnt_m <= cnt_m - 8'd1;
    if (rac) acc_m <= 8'd0;
    else if (cac) acc_m <= acc_m + value;
  end

  assign nill     = (cnt_m == 8'd0);
  assign overflow = ({1'b0, acc_m} + {1'b0, value}) > 9'd255;

  function automatic vec_t mk(logic st, logic ab, logic vl, logic [7:0] v, logic [9:0] eo,
                              logic [7:0] etc);
    vec_t r;
    r.start = st; r.abort = ab; r.valid = vl; r.value = v; r.exp_o = eo; r.exp_tc = etc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs_now();
    return {value_ready, set, rac, dec, cac, busy, done, error, err_code};
  endfunction

  // Called at posedge+1; drives a cycle, snapshots outputs mid-cycle, returns at next posedge+1.
  task automatic step(input logic st, input logic ab, input logic vl, input logic [7:0] v);
    start = st; abort = ab; value_valid = vl; value = v;
    #4;
    s_o  = outs_now();
    s_tc = term_count;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].value);
      check($sformatf("vec%0d", i), {14'd0, s_o, s_tc}, {14'd0, tbl[i].exp_o, tbl[i].exp_tc});
    end
  endtask

  initial begin
    int k;
    int done_seen;
    logic bad_seen;

    // T2: N=3, terms 10/20/30 back-to-back
    tbl[0]  = mk(1, 0, 0, 8'd0,   10'b0_0_0_0_0_0_0_0_00, 8'd0);
    tbl[1]  = mk(0, 0, 0, 8'd0,   10'b0_1_1_0_0_1_0_0_00, 8'd0);
    tbl[2]  = mk(0, 0, 1, 8'd10,  10'b1_0_0_1_1_1_0_0_00, 8'd0);
    tbl[3]  = mk(0, 0, 1, 8'd20,  10'b1_0_0_1_1_1_0_0_00, 8'd1);
    tbl[4]  = mk(0, 0, 1, 8'd30,  10'b1_0_0_1_1_1_0_0_00, 8'd2);
    tbl[5]  = mk(0, 0, 0, 8'd0,   10'b0_0_0_0_0_1_0_0_00, 8'd3);
    tbl[6]  = mk(0, 0, 0, 8'd0,   10'b0_0_0_0_0_0_1_0_00, 8'd3);
    tbl[7]  = mk(0, 0, 0, 8'd0,   10'b0_0_0_0_0_0_0_0_00, 8'd3);
    // T4: N=2, 200 then 100 overflows
    tbl[8]  = mk(1, 0, 0, 8'd0,   10'b0_0_0_0_0_0_0_0_00, 8'd3);
    tbl[9]  = mk(0, 0, 0, 8'd0,   10'b0_1_1_0_0_1_0_0_00, 8'd3);
    tbl[10] = mk(0, 0, 1, 8'd200, 10'b1_0_0_1_1_1_0_0_00, 8'd0);
    tbl[11] = mk(0, 0, 1, 8'd100, 10'b1_0_0_0_0_1_0_0_00, 8'd1);
    tbl[12] = mk(0, 0, 0, 8'd0,   10'b0_0_0_0_0_0_0_1_01, 8'd1);
    tbl[13] = mk(0, 0, 0, 8'd0,   10'b0_0_0_0_0_0_0_1_01, 8'd1);

    // Reset state
    #2;
    check("reset_outs", {22'd0, outs_now()}, 32'd0);
    check("reset_tc", {24'd0, term_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2
    n_load = 8'd3;
    run_table(0, 7);
    check("t2_acc", {24'd0, acc_m}, 32'd60);

    // T3: 5 idle cycles before each term
    n_load = 8'd3;
    bad_seen = 1'b0;
    step(1, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 5; j++) begin
        step(0, 0, 0, 8'd0);
        if (s_o[IErr] || s_o[ICac]) bad_seen = 1'b1;
      end
      step(0, 0, 1, 8'(10 * (t + 1)));
      check($sformatf("t3_accept%0d", t), {31'd0, s_o[ICac]}, 32'd1);
    end
    done_seen = 0;
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 8'd0);
      if (s_o[IDone]) done_seen++;
      if (s_o[IErr]) bad_seen = 1'b1;
    end
    check("t3_no_error", {31'd0, bad_seen}, 32'd0);
    check("t3_done_cycles", done_seen, 1);
    check("t3_tc", {24'd0, term_count}, 32'd3);
    check("t3_acc", {24'd0, acc_m}, 32'd60);

    // T4
    n_load = 8'd2;
    run_table(8, 13);
    check("t4_acc", {24'd0, acc_m}, 32'd200);

    // T5: timeout, then clean restart from ERROR
    n_load = 8'd3;
    step(1, 0, 0, 8'd0);
    check("t5_err_before_start", {30'd0, s_o[IErr], s_o[1:0]}, 32'b101);
    step(0, 0, 0, 8'd0);
    check("t5_init_clears_error", {31'd0, s_o[IErr]}, 32'd0);
    k = -1;
    for (int j = 0; j < 40; j++) begin
      step(0, 0, 0, 8'd0);
      if (s_o[IErr]) begin
        k = j;
        break;
      end
    end
    check("t5_timeout_cycle", k, 16);
    check("t5_err_code", {30'd0, s_o[1:0]}, 32'd2);
    check("t5_tc", {24'd0, s_tc}, 32'd0);
    n_load = 8'd1;
    step(1, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    step(0, 0, 1, 8'd5);
    check("t5_restart_accept", {31'd0, s_o[ICac]}, 32'd1);
    step(0, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    check("t5_restart_done", {28'd0, s_o[IDone], s_o[IErr], s_o[1:0]}, 32'b1000);
    check("t5_restart_tc", {24'd0, s_tc}, 32'd1);

    // T6: abort+start together in WAIT
    n_load = 8'd3;
    step(1, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    step(0, 0, 1, 8'd10);
    step(1, 1, 1, 8'd10);
    check("t6_abort_cycle_strobes",
          {27'd0, s_o[ISet], s_o[IRac], s_o[IDec], s_o[ICac], s_o[IDone]}, 32'd0);
    bad_seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 1, 8'd10);
      if (s_o[IBusy] || s_o[ICac] || s_o[IDec] || s_o[ISet] || s_o[IDone] || s_o[IReady])
        bad_seen = 1'b1;
    end
    check("t6_idle_after_abort", {31'd0, bad_seen}, 32'd0);
    check("t6_acc", {24'd0, acc_m}, 32'd10);

    // T1: asynchronous reset mid-WAIT
    n_load = 8'd3;
    step(1, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    step(0, 0, 1, 8'd7);
    value_valid = 1'b1;
    value = 8'd7;
    rst_n = 1'b0;
    #1;
    check("t1_async_outs", {22'd0, outs_now()}, 32'd0);
    check("t1_async_tc", {24'd0, term_count}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad_seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 1, 8'd7);
      if (s_o[ICac] || s_o[IBusy] || s_o[IRac]) bad_seen = 1'b1;
    end
    check("t1_no_cac_after_release", {31'd0, bad_seen}, 32'd0);
    check("t1_acc_kept", {24'd0, acc_m}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
